// File: rtl/router_egress_queue.sv
// Egress FIFO for one router output port: buffers routed bytes, serves them over
// valid/ready, and counts overflow drops. Define ROUTER_EGRESS_HWM_EN to add the hwm output.
module router_egress_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       port_en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           drop_cnt,
`ifdef ROUTER_EGRESS_HWM_EN
  output logic [$clog2(DEPTH):0]     hwm,
`endif
  input  logic                       clr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              pop, push, drop, accept, wr_en, is_full;

  always_comb begin
    is_full  = (count_q == CW'(DEPTH));
    pop      = (count_q != '0) && out_ready;
    accept   = in_valid && port_en;
    push     = accept && (!is_full || pop);
    drop     = accept && is_full && !pop;
    wr_en    = push && !flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    drop_cnt_d = drop_cnt_q;
    if (clr_drop)
      drop_cnt_d = '0;
    else if (drop && !flush && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 1'b1;

    // Head register tracks the next-cycle head; a byte written into the slot that
    // becomes the head is forwarded so it appears one cycle after the push.
    out_data_d = out_data_q;
    if (count_d != '0)
      out_data_d = (wr_en && wr_ptr_q == rd_ptr_d) ? in_data : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef ROUTER_EGRESS_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (flush)
      hwm_d = '0;
    else if (clr_drop)
      hwm_d = count_d;
    else if (count_d > hwm_q)
      hwm_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  assign count     = count_q;
  assign full      = is_full;
  assign empty     = (count_q == '0);
  assign out_valid = (count_q != '0);
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
